frac_clkdiv: RTL

FRAC_CLKDIV -- requirements
Module: frac_clkdiv

---
 rtl/frac_clkdiv_pkg.sv | 16 +
 rtl/frac_clkdiv_chan.sv | 130 +++++++++++++
 rtl/frac_clkdiv.sv | 42 ++++
 3 files changed

// File: rtl/frac_clkdiv_pkg.sv
// Shared constants and the divide-code type for the fractional clock divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frac_clkdiv_pkg;

    // Smallest legal divide code (ratio 2.0); smaller codes are clamped to this.
    localparam int DIV_MIN = 4;

    // Accumulator advance per hclkin cycle, in half-cycle units.
    localparam int ACC_STEP = 2;

    // Default divide-code width and the matching code type.
    localparam int DIV_W_DEF = 8;
    typedef logic [DIV_W_DEF-1:0] div_code_t;

endpackage

// File: rtl/frac_clkdiv_chan.sv
// One fractional divider channel: half-cycle phase accumulator, high-time counter, pending code.
// Latency: all outputs registered, one hclkin cycle after the evaluating edge.
// Backpressure: none; free-running, load/calib are single-cycle strobes with no handshake.
module frac_clkdiv_chan
    import frac_clkdiv_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 7
) (
    input  logic             hclkin,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             load,
    input  logic             calib,
    output logic             ce,
    output logic             clkout,
    output logic             load_ack,
    output logic             err
);

    localparam logic [DIV_W-1:0] DIV_MIN_C = DIV_W'(DIV_MIN);
    localparam logic [DIV_W:0]   STEP_C    = (DIV_W+1)'(ACC_STEP);
    localparam logic [DIV_W-1:0] ONE_C     = DIV_W'(1);

    logic [DIV_W:0]   acc_q, acc_d, acc_sum;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [DIV_W-1:0] hi_cnt_q, hi_cnt_d;
    logic             ce_q, ce_d;
    logic             clkout_q, clkout_d;
    logic             load_ack_q, load_ack_d;
    logic             err_q, err_d;

    logic [DIV_W-1:0] load_code;
    logic [DIV_W-1:0] pend_eff;
    logic             pend_eff_vld;
    logic             wrap;
    logic             apply;
    logic [DIV_W-1:0] hi_len;

    // Next-state: accumulate, detect period wrap, swap in pending code at boundaries, shape clkout.
    always_comb begin
        // A fresh load in this cycle is visible to a coincident boundary (last write wins).
        load_code    = (div_in < DIV_MIN_C) ? DIV_MIN_C : div_in;
        pend_eff     = load ? load_code : pend_q;
        pend_eff_vld = load | pend_vld_q;

        acc_sum = acc_q + STEP_C;
        // calib suppresses the wrap entirely; it is re-evaluated next cycle from the held acc.
        wrap    = en && !calib && (acc_sum >= {1'b0, div_act_q});

        acc_d      = acc_q;
        div_act_d  = div_act_q;
        pend_d     = pend_eff;
        pend_vld_d = pend_eff_vld;
        hi_cnt_d   = hi_cnt_q;
        ce_d       = 1'b0;
        clkout_d   = clkout_q;
        load_ack_d = 1'b0;
        err_d      = err_q | (load && (div_in < DIV_MIN_C));

        // While disabled there is no period in flight, so a pending code applies immediately.
        apply = pend_eff_vld && (wrap || !en);
        if (apply) begin
            div_act_d  = pend_eff;
            pend_vld_d = 1'b0;
            load_ack_d = 1'b1;
        end

        // High time follows the code that governs the period just starting.
        hi_len = div_act_d >> 2;
        if (hi_len == '0) begin
            hi_len = ONE_C;
        end

        if (!en) begin
            acc_d    = '0;
            hi_cnt_d = '0;
            clkout_d = 1'b0;
        end else if (calib) begin
            // Phase slip: hold acc, high-time counter and clkout level for one cycle.
        end else if (wrap) begin
            // Residual is taken against the code that was active for the ending period.
            acc_d    = acc_sum - {1'b0, div_act_q};
            ce_d     = 1'b1;
            clkout_d = 1'b1;
            hi_cnt_d = hi_len - ONE_C;
        end else begin
            acc_d = acc_sum;
            if (hi_cnt_q != '0) begin
                hi_cnt_d = hi_cnt_q - ONE_C;
            end else begin
                clkout_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset overriding every strobe.
    always_ff @(posedge hclkin) begin
        if (reset) begin
            acc_q      <= '0;
            div_act_q  <= DIV_W'(DIV_DEFAULT);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            hi_cnt_q   <= '0;
            ce_q       <= 1'b0;
            clkout_q   <= 1'b0;
            load_ack_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            div_act_q  <= div_act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            hi_cnt_q   <= hi_cnt_d;
            ce_q       <= ce_d;
            clkout_q   <= clkout_d;
            load_ack_q <= load_ack_d;
            err_q      <= err_d;
        end
    end

    assign ce       = ce_q;
    assign clkout   = clkout_q;
    assign load_ack = load_ack_q;
    assign err      = err_q;

endmodule

// File: rtl/frac_clkdiv.sv
// Multi-channel fractional clock divider; each channel divides hclkin by D/2 independently.
// Latency: outputs registered, one hclkin cycle after the evaluating edge.
// Backpressure: none; free-running, strobes are fire-and-forget.
module frac_clkdiv
    import frac_clkdiv_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DIV_DEFAULT = 7
) (
    input  logic                      hclkin,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*DIV_W-1:0] div_in,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS-1:0]       calib,
    output logic [CHANNELS-1:0]       ce,
    output logic [CHANNELS-1:0]       clkout,
    output logic [CHANNELS-1:0]       load_ack,
    output logic [CHANNELS-1:0]       err
);

    // One fully independent divider per channel; only clock and reset are shared.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        frac_clkdiv_chan #(
            .DIV_W       (DIV_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_chan (
            .hclkin   (hclkin),
            .reset    (reset),
            .en       (en[i]),
            .div_in   (div_in[i*DIV_W +: DIV_W]),
            .load     (load[i]),
            .calib    (calib[i]),
            .ce       (ce[i]),
            .clkout   (clkout[i]),
            .load_ack (load_ack[i]),
            .err      (err[i])
        );
    end

endmodule
